// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - shared op/state encodings and helpers for the multiply/divide unit
package ex_muldiv_pkg;

    localparam int ITER = 32;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (32'd0 - x) : x;
    endfunction

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    function automatic logic is_hilo_op(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd6);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - EX-stage request/response bundle for the multiply/divide unit
interface ex_muldiv_if;

    logic        inStart;
    logic [2:0]  inOp;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        inReadHiLo;
    logic        inFlush;
    logic [31:0] outHI;
    logic [31:0] outLO;
    logic        outBusy;
    logic        outDone;
    logic        outStall;

    modport master (
        output inStart, inOp, inA, inB, inReadHiLo, inFlush,
        input  outHI, outLO, outBusy, outDone, outStall
    );

    modport slave (
        input  inStart, inOp, inA, inB, inReadHiLo, inFlush,
        output outHI, outLO, outBusy, outDone, outStall
    );

endinterface

// File: rtl/ex_muldiv_core.sv
// rtl/ex_muldiv_core.sv - md_core: iterative shift-add multiply / restoring divide datapath
module md_core
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_step,
    input  md_op_e      i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic        r_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic [31:0] r_m;
    logic [31:0] r_acc_hi;
    logic [31:0] r_acc_lo;

    logic        w_signed;
    logic        w_div;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_nhi;
    logic [31:0] w_nlo;
    logic [63:0] w_prod;

    assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
    assign w_div    = (i_op == MD_DIV)  || (i_op == MD_DIVU);
    assign w_mag_a  = mag32(i_a, w_signed);
    assign w_mag_b  = mag32(i_b, w_signed);

    // Multiply keeps the multiplier in acc_lo; divide keeps the dividend there and shifts it into the remainder.
    assign w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_m} : 33'd0);
    assign w_shift = {r_acc_hi, r_acc_lo[31]};
    assign w_diff  = w_shift - {1'b0, r_m};
    assign w_ge    = (w_shift >= {1'b0, r_m});

    always_comb begin
        w_nhi = w_sum[32:1];
        w_nlo = {w_sum[0], r_acc_lo[31:1]};
        if (r_div) begin
            w_nhi = w_ge ? w_diff[31:0] : w_shift[31:0];
            w_nlo = {r_acc_lo[30:0], w_ge};
        end
    end

    // Results reflect the step taken on this edge so the final edge can write HI/LO directly.
    assign w_prod = r_neg_q ? (64'd0 - {w_nhi, w_nlo}) : {w_nhi, w_nlo};

    always_comb begin
        o_hi = w_prod[63:32];
        o_lo = w_prod[31:0];
        if (r_div) begin
            o_hi = r_neg_r ? (32'd0 - w_nhi) : w_nhi;
            o_lo = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - w_nlo) : w_nlo);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_m      <= 32'd0;
            r_acc_hi <= 32'd0;
            r_acc_lo <= 32'd0;
        end else if (i_load) begin
            r_div    <= w_div;
            r_neg_q  <= w_signed & (i_a[31] ^ i_b[31]);
            r_neg_r  <= w_signed & i_a[31];
            r_dz     <= w_div & (i_b == 32'd0);
            r_m      <= w_div ? w_mag_b : w_mag_a;
            r_acc_hi <= 32'd0;
            r_acc_lo <= w_div ? w_mag_a : w_mag_b;
        end else if (i_step) begin
            r_acc_hi <= w_nhi;
            r_acc_lo <= w_nlo;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - EX-stage multiply/divide unit: FSM, iteration counter, HI/LO and stall
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int ITER = ex_muldiv_pkg::ITER
) (
    input  logic       CLOCK,
    input  logic       RESET,
    ex_muldiv_if.slave bus
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_busy;
    logic             r_done;

    logic             w_md_op;
    logic             w_hilo_op;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [31:0]      w_core_hi;
    logic [31:0]      w_core_lo;

    assign w_md_op   = is_muldiv(bus.inOp);
    assign w_hilo_op = is_hilo_op(bus.inOp);
    assign w_load    = (r_state == ST_IDLE) && bus.inStart && w_md_op && !bus.inFlush;
    assign w_step    = (r_state == ST_BUSY) && !bus.inFlush;
    assign w_last    = (r_cnt == CNT_W'(ITER - 1));

    md_core u_core (
        .clk    (CLOCK),
        .rst_n  (RESET),
        .i_load (w_load),
        .i_step (w_step),
        .i_op   (md_op_e'(bus.inOp)),
        .i_a    (bus.inA),
        .i_b    (bus.inB),
        .o_hi   (w_core_hi),
        .o_lo   (w_core_lo)
    );

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Flush beats everything, including a start or the final write-back edge.
            if (bus.inFlush) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.inStart && w_md_op) begin
                            r_state <= ST_BUSY;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                        end else if (bus.inStart && (bus.inOp == MD_MTHI)) begin
                            r_hi <= bus.inA;
                        end else if (bus.inStart && (bus.inOp == MD_MTLO)) begin
                            r_lo <= bus.inA;
                        end
                    end
                    ST_BUSY: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_hi    <= w_core_hi;
                            r_lo    <= w_core_lo;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.outHI    = r_hi;
    assign bus.outLO    = r_lo;
    assign bus.outBusy  = r_busy;
    assign bus.outDone  = r_done;
    assign bus.outStall = r_busy & (bus.inReadHiLo | (bus.inStart & w_hilo_op));

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv against an arithmetic reference model
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ex_muldiv_if bus ();

    ex_muldiv #(.ITER(32)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic ref_model(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] hi, output logic [31:0] lo);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (op)
            MD_MULT:  p = sa * sb;
            MD_MULTU: p = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            default: p = 64'd0;
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic start_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        bus.inStart = 1'b1;
        bus.inOp    = op;
        bus.inA     = a;
        bus.inB     = b;
        tick();
        bus.inStart = 1'b0;
        bus.inOp    = MD_NOP;
        bus.inA     = $urandom;
        bus.inB     = $urandom;
    endtask

    task automatic wait_done(output int nb, output bit dn);
        nb = 0;
        dn = 1'b0;
        for (int i = 0; i < 100 && !dn; i++) begin
            if (bus.outBusy) nb++;
            if (bus.outDone) dn = 1'b1;
            else begin
                bus.inA = $urandom;
                bus.inB = $urandom;
                tick();
            end
        end
    endtask

    task automatic test_reset();
        #3 RESET = 1'b0;
        #1;
        total++; if (bus.outHI !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.outHI); end
        total++; if (bus.outLO !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.outLO); end
        total++; if (bus.outBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.outBusy); end
        total++; if (bus.outDone !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.outDone); end
        tick();
        tick();
        RESET = 1'b1;
        tick();
    endtask

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic test_directed();
        vec_t v[6];
        int   nb;
        bit   dn;
        v[0] = '{MD_MULTU, 32'd7,           32'd6,           32'd0,           32'd42};
        v[1] = '{MD_MULT,  32'hFFFF_FFFD,   32'd5,           32'hFFFF_FFFF,   32'hFFFF_FFF1};
        v[2] = '{MD_DIV,   32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   32'hFFFF_FFFD};
        v[3] = '{MD_DIVU,  32'd10,          32'd0,           32'd10,          32'hFFFF_FFFF};
        v[4] = '{MD_DIV,   32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           32'h8000_0000};
        v[5] = '{MD_DIV,   32'hFFFF_FFF9,   32'd0,           32'hFFFF_FFF9,   32'hFFFF_FFFF};
        foreach (v[i]) begin
            start_op(v[i].op, v[i].a, v[i].b);
            wait_done(nb, dn);
            total++; if (!dn) begin bad++; $display("FAIL dir%0d_done timeout", i); end
            total++; if (nb != 32) begin bad++; $display("FAIL dir%0d_busy_cycles got=%0d want=32", i, nb); end
            total++; if (bus.outHI !== v[i].hi) begin bad++; $display("FAIL dir%0d_hi got=%h want=%h", i, bus.outHI, v[i].hi); end
            total++; if (bus.outLO !== v[i].lo) begin bad++; $display("FAIL dir%0d_lo got=%h want=%h", i, bus.outLO, v[i].lo); end
            tick();
            total++; if (bus.outDone !== 1'b0) begin bad++; $display("FAIL dir%0d_done_pulse got=%b want=0", i, bus.outDone); end
        end
    endtask

    task automatic test_back_to_back();
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          nb;
        bit          dn;
        for (int i = 0; i < 24; i++) begin
            op = md_op_e'($urandom_range(1, 4));
            a  = rand_opnd();
            b  = rand_opnd();
            ref_model(op, a, b, eh, el);
            start_op(op, a, b);
            wait_done(nb, dn);
            total++; if (!dn || nb != 32) begin bad++; $display("FAIL b2b%0d_timing done=%b busy=%0d want 1/32", i, dn, nb); end
            total++; if (bus.outHI !== eh || bus.outLO !== el) begin
                bad++; $display("FAIL b2b%0d op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h", i, op, a, b, bus.outHI, bus.outLO, eh, el);
            end
        end
        tick();
    endtask

    task automatic test_mt();
        logic [31:0] x;
        logic [31:0] y;
        x = $urandom;
        y = $urandom;
        bus.inStart = 1'b1; bus.inOp = MD_MTHI; bus.inA = x;
        tick();
        bus.inOp = MD_MTLO; bus.inA = y;
        total++; if (bus.outHI !== x) begin bad++; $display("FAIL mthi got=%h want=%h", bus.outHI, x); end
        total++; if (bus.outBusy !== 1'b0 || bus.outDone !== 1'b0) begin bad++; $display("FAIL mthi_flags busy=%b done=%b want 0/0", bus.outBusy, bus.outDone); end
        tick();
        bus.inOp = MD_RSVD; bus.inA = ~x;
        total++; if (bus.outLO !== y) begin bad++; $display("FAIL mtlo got=%h want=%h", bus.outLO, y); end
        total++; if (bus.outBusy !== 1'b0 || bus.outDone !== 1'b0) begin bad++; $display("FAIL mtlo_flags busy=%b done=%b want 0/0", bus.outBusy, bus.outDone); end
        tick();
        bus.inStart = 1'b0; bus.inOp = MD_NOP;
        total++; if (bus.outHI !== x || bus.outLO !== y || bus.outBusy !== 1'b0) begin
            bad++; $display("FAIL op7_nop hi=%h lo=%h busy=%b want %h %h 0", bus.outHI, bus.outLO, bus.outBusy, x, y);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        bit          dn;
        a = $urandom;
        b = $urandom;
        ref_model(MD_MULTU, a, b, eh, el);
        bus.inReadHiLo = 1'b1;
        #1;
        total++; if (bus.outStall !== 1'b0) begin bad++; $display("FAIL stall_idle got=%b want=0", bus.outStall); end
        bus.inReadHiLo = 1'b0;
        start_op(MD_MULTU, a, b);
        repeat (4) tick();
        bus.inReadHiLo = 1'b1;
        dn = 1'b0;
        for (int cyc = 5; cyc < 100 && !dn; cyc++) begin
            bus.inStart = (cyc >= 10 && cyc <= 20);
            bus.inOp    = bus.inStart ? MD_DIVU : MD_NOP;
            #1;
            if (bus.outDone) begin
                dn = 1'b1;
                total++; if (bus.outStall !== 1'b0) begin bad++; $display("FAIL stall_done_cycle got=%b want=0", bus.outStall); end
                total++; if (bus.outHI !== eh || bus.outLO !== el) begin
                    bad++; $display("FAIL stall_result got hi=%h lo=%h want hi=%h lo=%h", bus.outHI, bus.outLO, eh, el);
                end
            end else begin
                total++; if (bus.outStall !== 1'b1) begin bad++; $display("FAIL stall_busy cyc=%0d got=%b want=1", cyc, bus.outStall); end
                tick();
            end
        end
        total++; if (!dn) begin bad++; $display("FAIL stall_timeout done never seen"); end
        bus.inReadHiLo = 1'b0;
        bus.inStart    = 1'b0;
        bus.inOp       = MD_NOP;
        tick();
        total++; if (bus.outBusy !== 1'b0) begin bad++; $display("FAIL stall_ignored_start busy=%b want=0", bus.outBusy); end
    endtask

    task automatic test_flush();
        bit seen;
        bus.inStart = 1'b1; bus.inOp = MD_MTHI; bus.inA = 32'd1;
        tick();
        bus.inOp = MD_MTLO; bus.inA = 32'd2;
        tick();
        bus.inStart = 1'b0;
        start_op(MD_MULTU, 32'd1000, 32'd3000);
        repeat (9) tick();
        bus.inFlush = 1'b1;
        tick();
        bus.inFlush = 1'b0;
        total++; if (bus.outBusy !== 1'b0) begin bad++; $display("FAIL flush10_busy got=%b want=0", bus.outBusy); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.outDone) seen = 1'b1;
            tick();
        end
        total++; if (seen) begin bad++; $display("FAIL flush10_done got=1 want=0"); end
        total++; if (bus.outHI !== 32'd1 || bus.outLO !== 32'd2) begin bad++; $display("FAIL flush10_hilo got=%h/%h want=1/2", bus.outHI, bus.outLO); end
        start_op(MD_DIVU, 32'd77, 32'd5);
        repeat (31) tick();
        bus.inFlush = 1'b1;
        tick();
        bus.inFlush = 1'b0;
        total++; if (bus.outBusy !== 1'b0 || bus.outDone !== 1'b0) begin bad++; $display("FAIL flush_last busy=%b done=%b want 0/0", bus.outBusy, bus.outDone); end
        total++; if (bus.outHI !== 32'd1 || bus.outLO !== 32'd2) begin bad++; $display("FAIL flush_last_hilo got=%h/%h want=1/2", bus.outHI, bus.outLO); end
        bus.inFlush = 1'b1;
        start_op(MD_MULT, 32'd5, 32'd5);
        bus.inFlush = 1'b0;
        total++; if (bus.outBusy !== 1'b0) begin bad++; $display("FAIL flush_vs_start busy=%b want=0", bus.outBusy); end
    endtask

    task automatic test_reset_mid();
        int nb;
        bit dn;
        start_op(MD_DIV, 32'hFFFF_F000, 32'd7);
        repeat (19) tick();
        #2 RESET = 1'b0;
        #1;
        total++; if (bus.outHI !== 32'd0 || bus.outLO !== 32'd0) begin bad++; $display("FAIL rstmid_hilo got=%h/%h want=0/0", bus.outHI, bus.outLO); end
        total++; if (bus.outBusy !== 1'b0 || bus.outDone !== 1'b0 || bus.outStall !== 1'b0) begin
            bad++; $display("FAIL rstmid_flags busy=%b done=%b stall=%b want 0/0/0", bus.outBusy, bus.outDone, bus.outStall);
        end
        tick();
        RESET = 1'b1;
        bus.inStart = 1'b1; bus.inOp = MD_MTLO; bus.inA = 32'd5;
        tick();
        bus.inStart = 1'b0; bus.inOp = MD_NOP;
        total++; if (bus.outLO !== 32'd5) begin bad++; $display("FAIL rstmid_mtlo got=%h want=5", bus.outLO); end
        start_op(MD_MULTU, 32'd3, 32'd4);
        total++; if (bus.outBusy !== 1'b1) begin bad++; $display("FAIL rstmid_restart busy=%b want=1", bus.outBusy); end
        wait_done(nb, dn);
        total++; if (!dn || bus.outLO !== 32'd12 || bus.outHI !== 32'd0) begin
            bad++; $display("FAIL rstmid_result done=%b hi=%h lo=%h want 1 0 c", dn, bus.outHI, bus.outLO);
        end
        tick();
    endtask

    initial begin
        bus.inStart    = 1'b0;
        bus.inOp       = MD_NOP;
        bus.inA        = 32'd0;
        bus.inB        = 32'd0;
        bus.inReadHiLo = 1'b0;
        bus.inFlush    = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_mt();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
